arb_if: RTL and testbench
=========================

ARB_IF -- requirements
Module: arb_if

Interface
REQ-001 Parameter N, default 2: number of requesters; legal range 2..16.
REQ-002 Parameter MODE (arb_pkg::arb_mode_e), default ARB_FIXED: ARB_FIXED gives fixed priority, ARB_RR gives round-robin.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-005 request  input  N  per-requester level request; bit i set means requester i wants access.
REQ-006 grant  output  N  registered one-hot-or-zero grant; bit i set means requester i owns the resource this cycle.
REQ-007 grant_valid  output  1  registered; high exactly when grant is non-zero.
REQ-008 grant_id  output  $clog2(N)  registered binary index of the granted requester; 0 when grant_valid is low.

Function
REQ-009 Every rising edge of clk without rst SHALL recompute grant, grant_valid and grant_id from the request value sampled at that edge; latency is 1 cycle.
REQ-010 grant SHALL never have more than one bit set.
REQ-011 ARB_FIXED: the lowest-index asserted request wins. For N=2: request 01 gives 01, 10 gives 10, 11 gives 01, 00 gives 00.
REQ-012 ARB_RR: the winner is the first asserted request at or after index ptr, searching upward and wrapping from N-1 to 0.
REQ-013 ARB_RR: after each edge that issues a grant to index k, ptr SHALL become (k+1) mod N.
REQ-014 ARB_RR: ptr SHALL hold its value on edges with no grant.
REQ-015 Grants are not sticky: a requester that keeps request high is re-arbitrated every cycle (ARB_FIXED lets it hold; ARB_RR rotates it against competitors).
REQ-016 When request is all-zero at an edge, grant SHALL be 0, grant_valid 0 and grant_id 0 after that edge.
REQ-017 If request deasserts, grant SHALL drop on the next edge with no extra hold cycle.
REQ-018 A new request arriving in the same cycle that another deasserts SHALL be handled by normal arbitration of the sampled vector; no bubble cycle.
REQ-019 Outputs SHALL be driven only by flops; there is no combinational path from request to grant.

Reset
REQ-020 With rst high at a rising edge, grant=0, grant_valid=0, grant_id=0 and ptr=0 after that edge, regardless of request.
REQ-021 rst SHALL take precedence over any simultaneous request.
REQ-022 Reset asserted mid-operation SHALL clear the grant on that edge.
REQ-023 The first edge after rst falls SHALL arbitrate normally; ARB_RR starts searching from index 0.
REQ-024 Before the first reset edge the outputs are don't-care; the bench SHALL not check them.

Structure
REQ-025 Package arb_pkg SHALL hold the enum arb_mode_e {ARB_FIXED, ARB_RR} and the constant ARB_MAX_N = 16.
REQ-026 One sub-module, arb_prio_pick, SHALL be used:
- Inputs: N-bit vector and start index.
- Outputs: one-hot winner, binary index, found flag.
- ARB_FIXED drives start index 0.
REQ-027 An elaboration-time check SHALL reject N outside 2..16.

Verification
REQ-028 Reset check: rst=1 for 2 edges with request=11 -> grant=00, grant_valid=0, grant_id=0.
REQ-029 Single request: N=2, ARB_FIXED, request=01 applied after edge 1 -> grant=01 and grant_id=0 from edge 2; grant must still equal 01 two edges after the stimulus.
REQ-030 Fixed-priority ordering: N=2, ARB_FIXED, request sequence 10, 11, 00 on successive edges -> grant sequence 10, 01, 00, each one edge later.
REQ-031 Round-robin rotation: N=4, ARB_RR, request=1111 held for 5 edges -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-032 Round-robin wrap:
- Setup: N=4, ARB_RR, ptr=3, request=0011.
- Expected: grant=0001, then 0010 on the next edge.
REQ-033 Mid-operation reset: grant=10 active, rst pulsed for 1 edge with request=10 held -> grant=00 that edge and 10 on the following edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter: arbitration mode enum,
// size limit, and a wrap-around index adder used by the picker and the top.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int ARB_MAX_N = 16;

  // (a + b) mod n for a, b already in 0..n-1; avoids a general modulo.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Circular priority picker: finds the first set bit of req_i at or after
// start_i, wrapping from N-1 back to 0.
import arb_pkg::*;

module arb_prio_pick #(
  parameter int  N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] pos;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    pos      = '0;
    // Walk offsets 0..N-1 from start; the first hit latches found_o and blocks later ones.
    for (int off = 0; off < N; off++) begin
      pos = IW'(wrap_add(int'(start_i), off, N));
      if (!found_o && req_i[pos]) begin
        found_o       = 1'b1;
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
      end
    end
  end

endmodule

// File: rtl/arb_if.sv
// N-way arbiter with registered one-hot grant; fixed priority (lowest index
// wins) or round-robin with a pointer that advances past each winner.
import arb_pkg::*;

module arb_if #(
  parameter int                 N    = 2,
  parameter arb_pkg::arb_mode_e MODE = ARB_FIXED,
  localparam int                IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  request,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);

  generate
    if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
      $error("arb_if: N must be within 2..%0d", ARB_MAX_N);
    end
  endgenerate

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] start_idx;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

  logic [N-1:0]  grant_q;
  logic          grant_valid_q;
  logic [IW-1:0] grant_id_q;

  // Fixed priority is simply the circular search anchored at index 0.
  assign start_idx = (MODE == ARB_RR) ? ptr_q : '0;

  arb_prio_pick #(.N(N)) u_pick (
    .req_i    (request),
    .start_i  (start_idx),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign ptr_d = pick_found ? IW'(wrap_add(int'(pick_idx), 1, N)) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
    end else begin
      grant_q       <= pick_onehot;
      grant_valid_q <= pick_found;
      grant_id_q    <= pick_idx;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_arb_if.sv
// Directed bench for arb_if: fixed N=2, round-robin N=4 and N=3 instances share
// clk/rst; expected grants are queued at drive time and checked after the edge.
import arb_pkg::*;

module tb_arb_if;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req2 = '0;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;

  logic [1:0] g2;  logic v2;  logic [0:0] id2;
  logic [3:0] g4;  logic v4;  logic [1:0] id4;
  logic [2:0] g3;  logic v3;  logic [1:0] id3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         step_no;
    logic [1:0] e2;
    logic [3:0] e4;
    logic [2:0] e3;
  } exp_t;

  exp_t sb[$];
  int   step_cnt = 0;

  always #5 clk = ~clk;

  arb_if #(.N(2), .MODE(ARB_FIXED)) u_fix2 (
    .clk(clk), .rst(rst), .request(req2),
    .grant(g2), .grant_valid(v2), .grant_id(id2)
  );

  arb_if #(.N(4), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .rst(rst), .request(req4),
    .grant(g4), .grant_valid(v4), .grant_id(id4)
  );

  arb_if #(.N(3), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .rst(rst), .request(req3),
    .grant(g3), .grant_valid(v3), .grant_id(id3)
  );

  function automatic int onehot_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string name, input int sn, input logic [15:0] g,
                           input logic v, input logic [15:0] id, input logic [15:0] eg);
    logic [15:0] ev;
    logic [15:0] eid;
    ev  = {15'd0, |eg};
    eid = 16'(onehot_idx(eg));
    cmp($sformatf("step%0d %s grant", sn, name), g, eg);
    cmp($sformatf("step%0d %s grant_valid", sn, name), {15'd0, v}, ev);
    cmp($sformatf("step%0d %s grant_id", sn, name), id, eid);
    $display("step %0d %s: grant=%0h valid=%0b id=%0d", sn, name, g, v, id);
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic step(input logic r, input logic [1:0] a, input logic [3:0] b,
                      input logic [2:0] c, input logic [1:0] ea,
                      input logic [3:0] eb, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req2 = a;
    req4 = b;
    req3 = c;
    step_cnt++;
    sb.push_back('{step_no: step_cnt, e2: ea, e4: eb, e3: ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_dut("fix2", e.step_no, {14'd0, g2}, v2, {15'd0, id2}, {14'd0, e.e2});
    check_dut("rr4",  e.step_no, {12'd0, g4}, v4, {14'd0, id4}, {12'd0, e.e4});
    check_dut("rr3",  e.step_no, {13'd0, g3}, v3, {14'd0, id3}, {13'd0, e.e3});
  endtask

  initial begin
    //    rst   req2   req4     req3    exp2   exp4     exp3
    step(1'b1, 2'b11, 4'b1111, 3'b111, 2'b00, 4'b0000, 3'b000); // reset wins over requests
    step(1'b1, 2'b11, 4'b1111, 3'b111, 2'b00, 4'b0000, 3'b000);
    step(1'b0, 2'b00, 4'b0000, 3'b000, 2'b00, 4'b0000, 3'b000); // idle, ptrs stay 0
    step(1'b0, 2'b01, 4'b1111, 3'b111, 2'b01, 4'b0001, 3'b001); // RR starts from 0
    step(1'b0, 2'b01, 4'b1111, 3'b111, 2'b01, 4'b0010, 3'b010);
    step(1'b0, 2'b01, 4'b1111, 3'b111, 2'b01, 4'b0100, 3'b100); // rr3 ptr wraps to 0
    step(1'b0, 2'b10, 4'b1111, 3'b111, 2'b10, 4'b1000, 3'b001);
    step(1'b0, 2'b11, 4'b1111, 3'b000, 2'b01, 4'b0001, 3'b000); // fixed: low index wins
    step(1'b0, 2'b00, 4'b0000, 3'b100, 2'b00, 4'b0000, 3'b100); // rr4 ptr holds at 1
    step(1'b0, 2'b10, 4'b0100, 3'b011, 2'b10, 4'b0100, 3'b001); // rr4 ptr -> 3
    step(1'b0, 2'b10, 4'b0011, 3'b011, 2'b10, 4'b0001, 3'b010); // wrap from 3 to 0
    step(1'b0, 2'b10, 4'b0011, 3'b011, 2'b10, 4'b0010, 3'b001);
    step(1'b1, 2'b10, 4'b1111, 3'b111, 2'b00, 4'b0000, 3'b000); // mid-operation reset
    step(1'b0, 2'b10, 4'b1111, 3'b111, 2'b10, 4'b0001, 3'b001); // RR restarts at 0
    step(1'b0, 2'b01, 4'b0110, 3'b101, 2'b01, 4'b0010, 3'b100); // hand-over, no bubble
    step(1'b0, 2'b00, 4'b0110, 3'b001, 2'b00, 4'b0100, 3'b001); // drop with no hold
    step(1'b0, 2'b11, 4'b0110, 3'b000, 2'b01, 4'b0010, 3'b000);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
